// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch sequencer states, condition codes and IR field positions.
package cpu_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCond = 2'b01,
    StEval = 2'b10,
    StFin  = 2'b11
  } branch_state_e;

  // Condition field encodings; decoded by the conditional flip-flop, not here.
  localparam logic [1:0] COND_ZR = 2'b00;
  localparam logic [1:0] COND_NZ = 2'b01;
  localparam logic [1:0] COND_PL = 2'b10;
  localparam logic [1:0] COND_MI = 2'b11;

  localparam int unsigned IR_COND_HI = 20;
  localparam int unsigned IR_COND_LO = 19;

  localparam int unsigned PC_STEP_DFLT = 4;

endpackage

// File: rtl/pc_register.sv
// Program-counter register: synchronous reset, load has priority over increment.
module pc_register #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(cpu_pkg::PC_STEP_DFLT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] pc_o
);

  logic [WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_STEP;  // wraps modulo 2^WIDTH
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/pc_branch_seq.sv
// Branch micro-sequencer (IDLE -> COND -> EVAL -> FIN) that owns the PC between branches.
module pc_branch_seq
  import cpu_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(PC_STEP_DFLT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      ir,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             con,
  input  logic             pc_inc,
  output logic             rsel_cond,
  output logic             rsel_target,
  output logic             con_in,
  output logic [WIDTH-1:0] pc,
  output logic             busy,
  output logic             done,
  output logic             taken
);

  branch_state_e state_q, state_d;
  logic          taken_q, taken_d;
  logic          pc_load, pc_inc_en;

  // The condition field is decoded downstream by the conditional flip-flop.
  logic unused_ir;
  assign unused_ir = ^ir;

  always_comb begin
    state_d   = state_q;
    taken_d   = taken_q;
    pc_load   = 1'b0;
    pc_inc_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCond;
        end else if (pc_inc) begin
          pc_inc_en = 1'b1;
        end
      end
      StCond: state_d = StEval;
      StEval: begin
        pc_load = con;
        taken_d = con;
        state_d = StFin;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      taken_q <= taken_d;
    end
  end

  pc_register #(
    .WIDTH   (WIDTH),
    .RESET_PC(RESET_PC),
    .PC_STEP (PC_STEP)
  ) u_pc_register (
    .clk       (clk),
    .rst       (rst),
    .load_i    (pc_load),
    .inc_i     (pc_inc_en),
    .load_val_i(bus_in),
    .pc_o      (pc)
  );

  assign rsel_cond   = (state_q == StCond);
  assign con_in      = (state_q == StCond);
  assign rsel_target = (state_q == StEval);
  assign done        = (state_q == StFin);
  assign busy        = (state_q != StIdle);
  assign taken       = taken_q;

endmodule

// File: tb/tb_pc_branch_seq.sv
// Bench for pc_branch_seq: cycle-level reference model plus directed branch scenarios.
module tb_pc_branch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] ir;
  logic [31:0] bus_in;
  logic        con;
  logic        pc_inc;
  logic        rsel_cond, rsel_target, con_in, busy, done, taken;
  logic [31:0] pc;

  int errors = 0;
  int checks = 0;

  pc_branch_seq #(
    .WIDTH   (32),
    .RESET_PC(32'h0),
    .PC_STEP (32'd4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ir         (ir),
    .bus_in     (bus_in),
    .con        (con),
    .pc_inc     (pc_inc),
    .rsel_cond  (rsel_cond),
    .rsel_target(rsel_target),
    .con_in     (con_in),
    .pc         (pc),
    .busy       (busy),
    .done       (done),
    .taken      (taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles-into-branch counter (0 = not branching) plus PC and taken flag.
  logic [31:0] m_pc;
  int          m_cyc;
  logic        m_taken;
  logic        chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc    <= 32'h0;
      m_cyc   <= 0;
      m_taken <= 1'b0;
    end else if (m_cyc == 0) begin
      if (start) m_cyc <= 1;
      else if (pc_inc) m_pc <= m_pc + 32'd4;
    end else begin
      m_cyc <= (m_cyc == 3) ? 0 : m_cyc + 1;
      if (m_cyc == 2) begin
        m_taken <= con;
        if (con) m_pc <= bus_in;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("busy", 32'(busy), 32'(m_cyc != 0));
      chk("con_in", 32'(con_in), 32'(m_cyc == 1));
      chk("rsel_cond", 32'(rsel_cond), 32'(m_cyc == 1));
      chk("rsel_target", 32'(rsel_target), 32'(m_cyc == 2));
      chk("done", 32'(done), 32'(m_cyc == 3));
      if (m_cyc == 3) chk("taken", 32'(taken), 32'(m_taken));
    end
  end

  // Full branch from IDLE; noise drives start/pc_inc during COND and EVAL.
  task automatic branch(input logic c, input logic [31:0] b, input logic noise,
                        input logic [31:0] exp_pc);
    @(negedge clk);
    start = 1'b1; con = ~c; bus_in = 32'h5555_AAAA;
    @(negedge clk);
    chk("lit_cond_strobe", 32'(con_in), 32'd1);
    start = noise; pc_inc = noise;
    @(negedge clk);
    chk("lit_eval_busy", 32'(busy), 32'd1);
    con = c; bus_in = b;
    @(negedge clk);
    chk("lit_fin_done", 32'(done), 32'd1);
    chk("lit_fin_taken", 32'(taken), 32'(c));
    chk("lit_fin_pc", pc, exp_pc);
    start = 1'b0; pc_inc = 1'b0; con = 1'b0;
    @(negedge clk);
    chk("lit_idle_busy", 32'(busy), 32'd0);
    chk("lit_idle_pc", pc, exp_pc);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pc_inc = 1'b0; con = 1'b0; bus_in = '0;
    ir = 32'h0010_0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("lit_reset_pc", pc, 32'h0);
    chk("lit_reset_taken", 32'(taken), 32'd0);

    // Fetch increments
    pc_inc = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("lit_inc_pc", pc, 32'(4 * i));
    end
    pc_inc = 1'b0;

    branch(1'b1, 32'h0000_0100, 1'b0, 32'h0000_0100);
    branch(1'b1, 32'h0000_0020, 1'b0, 32'h0000_0020);
    branch(1'b0, 32'hDEAD_0000, 1'b0, 32'h0000_0020);

    // start and pc_inc together in IDLE: increment dropped
    @(negedge clk);
    start = 1'b1; pc_inc = 1'b1;
    @(negedge clk);
    start = 1'b0; pc_inc = 1'b0;
    chk("lit_collide_pc", pc, 32'h0000_0020);
    repeat (3) @(negedge clk);
    chk("lit_collide_idle", 32'(busy), 32'd0);

    // Noise on start/pc_inc mid-branch is ignored
    branch(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0200);
    @(negedge clk);
    chk("lit_noise_no_rebranch", 32'(busy), 32'd0);

    // Wrap-around
    branch(1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC);
    pc_inc = 1'b1;
    @(negedge clk);
    pc_inc = 1'b0;
    chk("lit_wrap_pc", pc, 32'h0000_0000);

    // Reset during EVAL abandons the branch
    pc_inc = 1'b1;
    repeat (2) @(negedge clk);
    pc_inc = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("lit_rst_in_eval", 32'(rsel_target), 32'd1);
    rst = 1'b1; con = 1'b1; bus_in = 32'h0000_0040;
    @(negedge clk);
    rst = 1'b0; con = 1'b0;
    chk("lit_rst_pc", pc, 32'h0);
    chk("lit_rst_done", 32'(done), 32'd0);
    chk("lit_rst_taken", 32'(taken), 32'd0);
    chk("lit_rst_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    chk("lit_rst_stays", pc, 32'h0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
